ram8_burst_ctrl: RTL and testbench
==================================

Name: ram8_burst_ctrl

Overview:
- Upstream controller that drives the 8-word x 16-bit ram8 port bundle (in, address, load) and consumes its out.
- Accepts one burst command (start address, length, direction).
- Write bursts stream words from a valid/ready source into consecutive RAM words.
- Read bursts stream consecutive RAM words to a valid/ready sink. It is the sequencing stage between a loader/CPU-side requester and ram8.

Parameters:
ADDR_W, 3, RAM address width; depth = 2^ADDR_W (8 for ram8)
DATA_W, 16, data word width

Ports:
clk  input  1  rising-edge clock, shared with ram8
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller accepts command this cycle
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  ADDR_W  burst length minus one (0 => 1 word, 7 => 8 words)
wr_data  input  DATA_W  write-stream word
wr_valid  input  1  write word offered
wr_ready  output  1  write word accepted
rd_data  output  DATA_W  read-stream word
rd_valid  output  1  read word offered
rd_ready  input  1  sink accepts read word
ram_in  output  DATA_W  to ram8 in
ram_address  output  ADDR_W  to ram8 address
ram_load  output  1  to ram8 load
ram_out  input  DATA_W  from ram8 out; combinational function of ram_address; write lands at clk rising edge when ram_load=1
busy  output  1  burst in progress (state WRITE or READ)
done  output  1  one-cycle pulse after last word of a burst

Behaviour:
- States: IDLE, WRITE, READ, DONE. Registered state, addr_q (ADDR_W), rem_q (ADDR_W).
- Reset (async, immediate):
  - state=IDLE, addr_q=0, rem_q=0.
  - Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, ram_load=0, busy=0, done=0, ram_address=0.
  - rd_data follows ram_out; ram_in follows wr_data.
- ram_address = addr_q in all states. ram_in = wr_data in all states.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: addr_q<=cmd_addr, rem_q<=cmd_len; next state WRITE if cmd_write else READ.
  - No RAM activity in the accept cycle.
- WRITE:
  - wr_ready=1; ram_load=wr_valid (combinational). No write occurs without wr_valid.
  - On wr_valid (handshake): word written to addr_q at that edge; addr_q<=addr_q+1 mod 2^ADDR_W.
  - If rem_q==0, next state DONE; else rem_q<=rem_q-1.
  - wr_valid low: hold all state, ram_load=0.
- READ:
  - rd_valid=1; rd_data=ram_out, i.e. mem[addr_q].
  - While rd_ready=0, addr_q is held, so rd_data is stable.
  - On rd_ready (handshake): addr_q<=addr_q+1 mod 2^ADDR_W; rem_q/DONE transition as in WRITE.
  - ram_load=0 throughout.
- DONE:
  - done=1, cmd_ready=0, wr_ready=0, rd_valid=0 for exactly one cycle; next state IDLE.
  - Minimum command-to-command spacing: 1 accept cycle, N data cycles, 1 DONE cycle, then next accept.
- Throughput: one word per cycle when the stream is continuously valid/ready.
- Wrap-around: address increments modulo depth. An 8-word burst from 5 touches 5,6,7,0,1,2,3,4. A burst never exceeds depth, so no word is touched twice.
- cmd_* ignored outside IDLE. wr_valid ignored outside WRITE. rd_ready ignored outside READ.
- Reset mid-burst: burst abandoned, ram_load drops immediately, no done pulse. Words already written stay in RAM.
- busy=1 exactly in WRITE and READ.

Test Plan:
- Reset, then single write: cmd(write=1, addr=1, len=0) then wr_data=ABAB with wr_valid=1 -> one cycle ram_load=1, ram_address=1. Next cycle done=1. ram8 word 1 = ABAB. Following cycle cmd_ready=1.
- Write burst with wrap: cmd(write=1, addr=6, len=3), data 1111,2222,3333,4444 back-to-back -> addresses 6,7,0,1 on consecutive cycles, then done. Read burst cmd(addr=6, len=3) with rd_ready=1 -> rd_data 1111,2222,3333,4444 on 4 consecutive cycles.
- Write backpressure: 2-word write from address 2 with wr_valid low for 3 cycles between words -> ram_load=0 and addr held during gaps. Exactly 2 writes total; done one cycle after the 2nd word.
- Read stall: 3-word read from 0 with rd_ready low for 2 cycles on the first word -> rd_valid=1, rd_data constant (mem[0]) during the stall, ram_load=0. Words mem[0..2] delivered in order.
- Reset mid-burst: 8-word write from 0, assert reset after 3 words -> ram_load=0 and busy=0 immediately, no done pulse. Words 0..2 hold new data, words 3..7 unchanged.
- Ignored inputs: cmd_valid held high during a burst and during DONE -> no re-accept until IDLE (cmd_ready=0). wr_valid=1 while IDLE -> ram_load stays 0.

Source files
------------

// File: rtl/ram8_burst_ctrl.sv
// Burst sequencer between a command/stream requester and the ram8 port bundle.
// One command moves 1..2^ADDR_W consecutive words, wrapping at the top of the RAM.
module ram8_burst_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] ram_in_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic              ram_load_o,
  input  logic [DATA_W-1:0] ram_out_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  // The RAM always sees the current burst pointer and the write-stream word.
  assign ram_address_o = addr_q;
  assign ram_in_o      = wr_data_i;
  assign rd_data_o     = ram_out_i;

  // State, pointer and remaining-count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    ram_load_o  = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_len_i;
          state_d = cmd_write_i ? StWrite : StRead;
        end
      end
      StWrite: begin
        busy_o     = 1'b1;
        wr_ready_o = 1'b1;
        ram_load_o = wr_valid_i;
        if (wr_valid_i) begin
          addr_d = addr_q + ADDR_W'(1);
          if (rem_q == '0) state_d = StDone;
          else             rem_d   = rem_q - ADDR_W'(1);
        end
      end
      StRead: begin
        busy_o     = 1'b1;
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          addr_d = addr_q + ADDR_W'(1);
          if (rem_q == '0) state_d = StDone;
          else             rem_d   = rem_q - ADDR_W'(1);
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ram8_burst_ctrl.sv
// Directed and randomized bursts against a behavioural RAM and expected-memory model.
module tb_ram8_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [2:0]  cmd_addr = '0, cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0, rd_ready = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, ram_load, busy, done;
  logic [15:0] rd_data, ram_in, ram_out;
  logic [2:0]  ram_address;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [8];      // stands in for ram8
  logic [15:0] ref_mem [8];  // what the RAM should hold
  logic        preload = 1'b1;
  logic [15:0] wdata [8];
  int          gaps [8];

  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];

  // ram8 behaviour: combinational read, write at rising edge when load is set.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 8; k++) mem[k] <= ref_mem[k];
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  ram8_burst_ctrl #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .ram_in_o     (ram_in),
    .ram_address_o(ram_address),
    .ram_load_o   (ram_load),
    .ram_out_i    (ram_out),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic w, input logic [2:0] a, input logic [2:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("acc_ready", cmd_ready, 1);
    chk("acc_busy", busy, 0);
    chk("acc_load", ram_load, 0);
  endtask

  // DONE cycle, then back in IDLE; cmd_valid may still be high during DONE.
  task automatic finish_burst(input logic hold);
    @(negedge clk);
    cmd_valid = hold; wr_valid = 1'($urandom); rd_ready = 1'($urandom);
    #1;
    chk("done_pulse", done, 1);
    chk("done_cmdrdy", cmd_ready, 0);
    chk("done_busy", busy, 0);
    chk("done_load", ram_load, 0);
    chk("done_wrrdy", wr_ready, 0);
    chk("done_rdval", rd_valid, 0);
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("idle_done", done, 0);
    chk("idle_cmdrdy", cmd_ready, 1);
  endtask

  task automatic write_burst(input logic [2:0] a, input logic [2:0] l, input logic hold);
    logic [2:0] ea;
    accept(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = 3'(int'(a) + i);
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        cmd_valid = hold; cmd_addr = 3'($urandom);
        wr_valid = 1'b0; wr_data = 16'($urandom);
        #1;
        chk("wgap_load", ram_load, 0);
        chk("wgap_addr", ram_address, ea);
        chk("wgap_busy", busy, 1);
        chk("wgap_cmdrdy", cmd_ready, 0);
      end
      @(negedge clk);
      cmd_valid = hold; wr_valid = 1'b1; wr_data = wdata[i];
      #1;
      chk("w_load", ram_load, 1);
      chk("w_addr", ram_address, ea);
      chk("w_ready", wr_ready, 1);
      chk("w_in", ram_in, wdata[i]);
      chk("w_cmdrdy", cmd_ready, 0);
      ref_mem[ea] = wdata[i];
    end
    finish_burst(hold);
  endtask

  task automatic read_burst(input logic [2:0] a, input logic [2:0] l, input logic hold);
    logic [2:0] ea;
    accept(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = 3'(int'(a) + i);
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        cmd_valid = hold; rd_ready = 1'b0; wr_valid = 1'($urandom);
        #1;
        chk("rstall_valid", rd_valid, 1);
        chk("rstall_data", rd_data, ref_mem[ea]);
        chk("rstall_load", ram_load, 0);
      end
      @(negedge clk);
      cmd_valid = hold; rd_ready = 1'b1; wr_valid = 1'($urandom);
      #1;
      chk("r_valid", rd_valid, 1);
      chk("r_data", rd_data, ref_mem[ea]);
      chk("r_load", ram_load, 0);
      chk("r_busy", busy, 1);
    end
    finish_burst(hold);
  endtask

  task automatic check_mem();
    for (int k = 0; k < 8; k++) chk($sformatf("mem%0d", k), mem[k], ref_mem[k]);
  endtask

  task automatic clear_gaps();
    for (int k = 0; k < 8; k++) gaps[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) ref_mem[k] = 16'($urandom);
    clear_gaps();
    repeat (2) @(negedge clk);
    preload = 1'b0;
    wr_data = 16'h5a5a;
    #1;
    chk("rst_cmdrdy", cmd_ready, 1);
    chk("rst_wrrdy", wr_ready, 0);
    chk("rst_rdval", rd_valid, 0);
    chk("rst_load", ram_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_rddata", rd_data, ref_mem[0]);
    chk("rst_ramin", ram_in, 16'h5a5a);
    @(negedge clk);
    rst = 1'b0;

    // Single-word write.
    wdata[0] = 16'hABAB;
    write_burst(3'd1, 3'd0, 1'b0);
    check_mem();

    // Wrapping write then read back.
    wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
    write_burst(3'd6, 3'd3, 1'b0);
    read_burst(3'd6, 3'd3, 1'b0);
    check_mem();

    // Write backpressure: 3 idle cycles between two words.
    wdata[0] = 16'hC0DE; wdata[1] = 16'hBEEF;
    gaps[1] = 3;
    write_burst(3'd2, 3'd1, 1'b0);
    clear_gaps();
    check_mem();

    // Read stall on the first word.
    gaps[0] = 2;
    read_burst(3'd0, 3'd2, 1'b0);
    clear_gaps();

    // Command held high through a burst and its DONE cycle.
    wdata[0] = 16'h7777; wdata[1] = 16'h8888;
    write_burst(3'd4, 3'd1, 1'b1);
    check_mem();

    // wr_valid in IDLE must not write.
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    #1;
    chk("idle_wr_load", ram_load, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    check_mem();

    // Reset mid-burst after three words of an 8-word write.
    accept(1'b1, 3'd0, 3'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hF000 + 16'(i);
      #1;
      chk("mid_load", ram_load, 1);
      ref_mem[i] = 16'hF000 + 16'(i);
    end
    @(negedge clk);
    rst = 1'b1; wr_data = 16'hF003;
    #1;
    chk("mid_rst_load", ram_load, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", ram_address, 0);
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    chk("mid_post_done", done, 0);
    chk("mid_post_cmdrdy", cmd_ready, 1);
    check_mem();
    read_burst(3'd0, 3'd7, 1'b0);

    // Randomized bursts.
    for (int t = 0; t < 12; t++) begin
      logic [2:0] ra, rl;
      ra = 3'($urandom); rl = 3'($urandom);
      for (int k = 0; k < 8; k++) begin
        wdata[k] = 16'($urandom);
        gaps[k]  = int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) write_burst(ra, rl, 1'($urandom));
      else                           read_burst(ra, rl, 1'($urandom));
    end
    clear_gaps();
    check_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
